// File: rtl/kalman_pkg.sv
// kalman_pkg
//   Shared definitions for the Kalman datapath blocks. Holds the state
//   encoding and default sizing of the multiplier-sharing arbiter, plus
//   a small round-robin helper used when advancing the priority pointer.
package kalman_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int ARB_DWIDTH_DEFAULT = 64;
  localparam int ARB_NREQ_DEFAULT   = 4;
  localparam int ARB_DEPTH_DEFAULT  = 8;

  // Next requester index after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_tag_fifo.sv
// tag_fifo
//   Small synchronous FIFO holding the requester index of every multiply
//   that has been issued but not yet returned. The head entry tells the
//   arbiter which requester the next multiplier response belongs to.
//
// Ports
//   clk, rst    clock, synchronous active-high reset (empties the FIFO)
//   push        write push_data (ignored when full)
//   push_data   requester tag to store
//   pop         drop the head entry (ignored when empty)
//   head        oldest stored tag
//   empty/full  occupancy flags
//   count       number of stored tags, 0..DEPTH
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Shares one pipelined FP64 multiplier among NREQ requesters. Requests
//   are granted round-robin; a grant is locked for one handshake, then
//   the arbiter returns to idle (one bubble per request). The requester
//   index of every issued multiply is queued so in-order results can be
//   routed back to the right requester.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester request handshake
//   req_a, req_b             packed per-requester operands (slice i = requester i)
//   resp_valid/resp_ready    per-requester result handshake (resp_valid one-hot or zero)
//   resp_y                   result, broadcast to all requesters
//   m_req_*                  request port to the shared multiplier
//   m_resp_*                 response port from the multiplier (in issue order)
//   outstanding              issued, not yet returned multiplies
//   err_orphan               sticky: a response arrived with nothing outstanding
module mul_share_arbiter
  import kalman_pkg::*;
#(
  parameter int DWIDTH = ARB_DWIDTH_DEFAULT,
  parameter int NREQ   = ARB_NREQ_DEFAULT,
  parameter int DEPTH  = ARB_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DWIDTH-1:0] req_a,
  input  logic [NREQ*DWIDTH-1:0] req_b,
  output logic [NREQ-1:0]        resp_valid,
  input  logic [NREQ-1:0]        resp_ready,
  output logic [DWIDTH-1:0]      resp_y,
  output logic                   m_req_valid,
  input  logic                   m_req_ready,
  output logic [DWIDTH-1:0]      m_req_a,
  output logic [DWIDTH-1:0]      m_req_b,
  input  logic                   m_resp_valid,
  output logic                   m_resp_ready,
  input  logic [DWIDTH-1:0]      m_resp_y,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err_orphan
);

  localparam int TW = $clog2(NREQ);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [TW-1:0] grant;
  logic [TW-1:0] grant_nxt;
  logic [TW-1:0] rr_ptr;
  logic [TW-1:0] rr_ptr_nxt;
  logic [TW-1:0] winner;
  logic [TW-1:0] head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin : rr_search
    int            idx;
    logic [TW-1:0] idx_t;
    logic          found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idx_t  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx   = (int'(rr_ptr) + k) % NREQ;
      idx_t = TW'(idx);
      if (!found && req_valid[idx_t]) begin
        found  = 1'b1;
        winner = idx_t;
      end
    end
  end

  // The grant only opens while the tag FIFO has room, so a full arbiter
  // leaves pending requests waiting while responses keep draining.
  always_comb begin : arb_fsm
    state_nxt   = state;
    grant_nxt   = grant;
    rr_ptr_nxt  = rr_ptr;
    push        = 1'b0;
    m_req_valid = 1'b0;
    req_ready   = '0;
    case (state)
      ARB_IDLE: begin
        if ((|req_valid) && !fifo_full) begin
          grant_nxt = winner;
          state_nxt = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        m_req_valid      = req_valid[grant];
        req_ready[grant] = m_req_ready;
        if (!req_valid[grant]) begin
          state_nxt = ARB_IDLE;
        end else if (m_req_ready) begin
          push       = 1'b1;
          rr_ptr_nxt = TW'(rr_next(int'(grant), NREQ));
          state_nxt  = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign m_req_a = req_a[grant*DWIDTH +: DWIDTH];
  assign m_req_b = req_b[grant*DWIDTH +: DWIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Results return in issue order, so the FIFO head names the owner. A
  // stalled owner back-pressures the multiplier and blocks later results.
  always_comb begin : resp_route
    resp_valid = '0;
    if (m_resp_valid && !fifo_empty) begin
      resp_valid[head] = 1'b1;
    end
  end

  assign m_resp_ready = !fifo_empty && resp_ready[head];
  assign resp_y       = m_resp_y;
  assign pop          = m_resp_valid && m_resp_ready;

  // A response with no tag queued can only come from a fault upstream or
  // a multiplier that missed a reset; latch it until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_orphan <= 1'b0;
    end else if (m_resp_valid && fifo_empty) begin
      err_orphan <= 1'b1;
    end
  end

  tag_fifo #(
    .WIDTH (TW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (grant),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (outstanding)
  );

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
//   Scoreboard bench for mul_share_arbiter. A driver process plays the
//   requesters and a behavioural FP64 multiplier (fixed latency, real
//   arithmetic). Accepted requests push their expected product onto an
//   in-order scoreboard; a monitor pops it whenever a requester accepts
//   a result. Directed phases cover the named scenarios; a random phase
//   follows.
module tb_mul_share_arbiter;

  localparam int DWIDTH = 64;
  localparam int NREQ   = 4;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int LAT    = 3;

  typedef struct {
    int          id;
    logic [63:0] y;
  } exp_t;

  typedef struct {
    logic [63:0] y;
    int          due;
  } mres_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DWIDTH-1:0] req_a;
  logic [NREQ*DWIDTH-1:0] req_b;
  logic [NREQ-1:0]        resp_valid;
  logic [NREQ-1:0]        resp_ready;
  logic [DWIDTH-1:0]      resp_y;
  logic                   m_req_valid;
  logic                   m_req_ready;
  logic [DWIDTH-1:0]      m_req_a;
  logic [DWIDTH-1:0]      m_req_b;
  logic                   m_resp_valid;
  logic                   m_resp_ready;
  logic [DWIDTH-1:0]      m_resp_y;
  logic [CW-1:0]          outstanding;
  logic                   err_orphan;

  always #5 clk = ~clk;

  mul_share_arbiter #(
    .DWIDTH (DWIDTH),
    .NREQ   (NREQ),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_y       (resp_y),
    .m_req_valid  (m_req_valid),
    .m_req_ready  (m_req_ready),
    .m_req_a      (m_req_a),
    .m_req_b      (m_req_b),
    .m_resp_valid (m_resp_valid),
    .m_resp_ready (m_resp_ready),
    .m_resp_y     (m_resp_y),
    .outstanding  (outstanding),
    .err_orphan   (err_orphan)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Knobs written by the control process only.
  int          target [NREQ] = '{default: 0};
  int          prob_new  = 100;
  int          drop_prob = 0;
  int          rr_prob   = 100;
  int          mreq_prob = 100;
  bit          mult_en   = 1'b1;
  logic [3:0]  hold_mask = '0;
  bit          use_fixed = 1'b0;
  logic [63:0] fixed_a   = '0;
  logic [63:0] fixed_b   = '0;
  int          orphan_req = 0;

  // State written by the monitor only.
  int    issued_cnt [NREQ] = '{default: 0};
  int    model_out = 0;
  bit    err_exp   = 1'b0;
  exp_t  exp_q[$];
  mres_t mult_q[$];
  int    log_id[$];
  int    log_cyc[$];

  // State written by the driver only.
  int last_seen [NREQ] = '{default: 0};
  int orphan_done = 0;

  function automatic logic [63:0] mul_model(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic logic [63:0] rand_fp();
    real r;
    r = real'($urandom_range(4095, 1)) / 16.0;
    if ($urandom_range(1) == 1) r = -r;
    return $realtobits(r);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Configure traffic knobs for a phase.
  task automatic applyStimulus(input int pnew, input int pdrop, input int prr,
                               input int pmreq, input bit men);
    prob_new  = pnew;
    drop_prob = pdrop;
    rr_prob   = prob_rr_clip(prr);
    mreq_prob = pmreq;
    mult_en   = men;
  endtask

  function automatic int prob_rr_clip(input int p);
    return (p > 100) ? 100 : p;
  endfunction

  task automatic stop_and_drain(input int bound);
    int t;
    for (int i = 0; i < NREQ; i++) target[i] = issued_cnt[i];
    t = 0;
    while ((outstanding != '0 || req_valid != '0 || model_out != 0) && t < bound) begin
      tick();
      t++;
    end
    checkOutput("drain_outstanding", outstanding, 0);
    checkOutput("drain_req_valid", req_valid, 0);
  endtask

  // Driver: requesters and the behavioural multiplier, updated just after each edge.
  initial begin : driver
    req_valid    = '0;
    req_a        = '0;
    req_b        = '0;
    resp_ready   = '0;
    m_req_ready  = 1'b0;
    m_resp_valid = 1'b0;
    m_resp_y     = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (issued_cnt[i] != last_seen[i]) begin
          last_seen[i] = issued_cnt[i];
          req_valid[i] = 1'b0;
        end else if (req_valid[i] && $urandom_range(99) < drop_prob) begin
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && issued_cnt[i] < target[i] && $urandom_range(99) < prob_new) begin
          req_valid[i] = 1'b1;
          req_a[i*DWIDTH +: DWIDTH] = use_fixed ? fixed_a : rand_fp();
          req_b[i*DWIDTH +: DWIDTH] = use_fixed ? fixed_b : rand_fp();
        end
        resp_ready[i] = !hold_mask[i] && ($urandom_range(99) < rr_prob);
      end
      m_req_ready  = ($urandom_range(99) < mreq_prob);
      m_resp_valid = 1'b0;
      m_resp_y     = {$urandom, $urandom};
      if (mult_en && mult_q.size() > 0 && mult_q[0].due <= cyc) begin
        m_resp_valid = 1'b1;
        m_resp_y     = mult_q[0].y;
      end else if (orphan_req != orphan_done) begin
        orphan_done++;
        m_resp_valid = 1'b1;
      end
    end
  end

  // Monitor: compares registered state with the model, then applies this cycle's handshakes.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      mult_q.delete();
      model_out = 0;
      err_exp   = 1'b0;
    end else begin
      checkOutput("outstanding", outstanding, model_out);
      checkOutput("err_orphan", err_orphan, err_exp);
      checkOutput("resp_valid_onehot0", $onehot0(resp_valid), 1);
      checkOutput("req_ready_onehot0", $onehot0(req_ready), 1);
      checkOutput("resp_y_broadcast", resp_y, m_resp_y);
      if (m_resp_valid && model_out == 0) begin
        checkOutput("orphan_m_resp_ready", m_resp_ready, 0);
        checkOutput("orphan_resp_valid", resp_valid, 0);
        err_exp = 1'b1;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back('{id: i, y: mul_model(req_a[i*DWIDTH +: DWIDTH], req_b[i*DWIDTH +: DWIDTH])});
          model_out++;
          issued_cnt[i]++;
          log_id.push_back(i);
          log_cyc.push_back(cyc);
        end
      end
      if (m_req_valid && m_req_ready) begin
        mult_q.push_back('{y: mul_model(m_req_a, m_req_b), due: cyc + LAT});
      end
      for (int i = 0; i < NREQ; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          if (exp_q.size() == 0) begin
            checkOutput("resp_with_empty_scoreboard", 0, 1);
          end else begin
            checkOutput("resp_owner", i, exp_q[0].id);
            checkOutput("resp_y", resp_y, exp_q[0].y);
            void'(exp_q.pop_front());
            model_out--;
          end
        end
      end
      if (m_resp_valid && m_resp_ready && mult_q.size() > 0) begin
        void'(mult_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : control
    int t;
    int base;
    int base0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    tick();
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_resp_valid", resp_valid, 0);
    checkOutput("reset_m_req_valid", m_req_valid, 0);
    checkOutput("reset_m_resp_ready", m_resp_ready, 0);
    checkOutput("reset_outstanding", outstanding, 0);
    checkOutput("reset_err_orphan", err_orphan, 0);
    checkOutput("reset_resp_y", resp_y, m_resp_y);

    // Single request from requester 1: 2.0 * 3.0.
    $display("[TB] single request");
    applyStimulus(100, 0, 100, 100, 1'b1);
    use_fixed = 1'b1;
    fixed_a   = 64'h4000000000000000;
    fixed_b   = 64'h4008000000000000;
    target[1] = issued_cnt[1] + 1;
    t = 0;
    while (resp_valid == '0 && t < 40) begin tick(); t++; end
    checkOutput("single_resp_valid", resp_valid, 4'b0010);
    checkOutput("single_resp_y", resp_y, 64'h4018000000000000);
    use_fixed = 1'b0;
    stop_and_drain(100);

    // All requesters valid from reset: issue order 0,1,2,3,0, two cycles apart.
    $display("[TB] round robin");
    @(posedge clk);
    #1 rst = 1'b1;
    base = log_id.size();
    for (int i = 0; i < NREQ; i++) target[i] = issued_cnt[i] + 5;
    @(posedge clk);
    #1 rst = 1'b0;
    t = 0;
    while (log_id.size() < base + 5 && t < 60) begin tick(); t++; end
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("rr_order_%0d", k),
                  (base + k < log_id.size()) ? log_id[base + k] : -1, k % NREQ);
    end
    for (int k = 1; k < 5; k++) begin
      checkOutput($sformatf("rr_spacing_%0d", k),
                  (base + k < log_cyc.size()) ? log_cyc[base + k] - log_cyc[base + k - 1] : -1, 2);
    end
    stop_and_drain(300);

    // Multiplier silent: requester 0 fills all DEPTH slots then stalls.
    $display("[TB] full");
    applyStimulus(100, 0, 100, 100, 1'b0);
    base0 = issued_cnt[0];
    target[0] = issued_cnt[0] + 20;
    repeat (40) tick();
    checkOutput("full_issue_count", issued_cnt[0] - base0, DEPTH);
    checkOutput("full_outstanding", outstanding, DEPTH);
    checkOutput("full_req_ready", req_ready, 0);
    checkOutput("full_m_req_valid", m_req_valid, 0);
    mult_en = 1'b1;
    stop_and_drain(300);

    // Requester 2 withholds resp_ready: requester 0's later result waits.
    $display("[TB] in-order blocking");
    hold_mask = 4'b0100;
    target[2] = issued_cnt[2] + 1;
    t = 0;
    while (issued_cnt[2] < target[2] && t < 40) begin tick(); t++; end
    target[0] = issued_cnt[0] + 1;
    t = 0;
    while (issued_cnt[0] < target[0] && t < 40) begin tick(); t++; end
    repeat (12) tick();
    checkOutput("block_resp_valid", resp_valid, 4'b0100);
    checkOutput("block_m_resp_ready", m_resp_ready, 0);
    checkOutput("block_outstanding", outstanding, 2);
    hold_mask = '0;
    stop_and_drain(100);

    // Orphan response with nothing outstanding.
    $display("[TB] orphan");
    do_reset();
    tick();
    orphan_req++;
    tick();
    checkOutput("orphan_pulse_seen", m_resp_valid, 1);
    checkOutput("orphan_ready_low", m_resp_ready, 0);
    tick();
    checkOutput("orphan_flag_set", err_orphan, 1);
    repeat (5) tick();
    checkOutput("orphan_flag_sticky", err_orphan, 1);
    do_reset();
    tick();
    checkOutput("orphan_flag_cleared", err_orphan, 0);

    // Reset with three multiplies outstanding.
    $display("[TB] reset mid-operation");
    applyStimulus(100, 0, 100, 100, 1'b0);
    target[3] = issued_cnt[3] + 3;
    t = 0;
    while (outstanding != 3 && t < 40) begin tick(); t++; end
    checkOutput("midrst_outstanding_before", outstanding, 3);
    do_reset();
    tick();
    checkOutput("midrst_outstanding", outstanding, 0);
    checkOutput("midrst_m_req_valid", m_req_valid, 0);
    checkOutput("midrst_resp_valid", resp_valid, 0);
    checkOutput("midrst_req_ready", req_ready, 0);
    mult_en = 1'b1;
    stop_and_drain(100);

    // Randomized traffic with back-pressure on every interface.
    $display("[TB] random traffic");
    applyStimulus(60, 5, 70, 60, 1'b1);
    for (int i = 0; i < NREQ; i++) target[i] = issued_cnt[i] + 150;
    t = 0;
    while (t < 8000) begin
      tick();
      t++;
      if (issued_cnt[0] >= target[0] && issued_cnt[1] >= target[1] &&
          issued_cnt[2] >= target[2] && issued_cnt[3] >= target[3]) break;
    end
    applyStimulus(100, 0, 100, 100, 1'b1);
    stop_and_drain(500);
    checkOutput("random_scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
